// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time counter: the packed MM:SS.cc
// vector width, per-digit rollover limits and the field offsets of each
// BCD digit inside the packed vector.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 6 * DIGIT_W;

  // Highest legal value of each BCD digit before it rolls over to 0.
  localparam int CS_LO_MAX  = 9;
  localparam int CS_HI_MAX  = 9;
  localparam int SEC_LO_MAX = 9;
  localparam int SEC_HI_MAX = 5;
  localparam int MIN_LO_MAX = 9;
  localparam int MIN_HI_MAX = 5;

  // Bit offsets of each digit in {min_hi,min_lo,sec_hi,sec_lo,cs_hi,cs_lo}.
  localparam int CS_LO_OFF  = 0;
  localparam int CS_HI_OFF  = 4;
  localparam int SEC_LO_OFF = 8;
  localparam int SEC_HI_OFF = 12;
  localparam int MIN_LO_OFF = 16;
  localparam int MIN_HI_OFF = 20;

  typedef logic [TIME_W-1:0] time_vec_t;

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One BCD digit of the stopwatch carry chain. Counts 0..MAX on each inc
// and wraps to 0; carry_out is combinational so a whole chain of digits
// resolves its carries within a single clock edge.
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry_out
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  assign carry_out = inc && (value == MAX_V);

  // Digit register: clear on reset, advance or wrap on inc, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= (value == MAX_V) ? 4'd0 : value + 4'd1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time counter: divides the system clock down to a 10 ms tick,
// keeps elapsed time as BCD MM:SS.cc in a six-digit carry chain and keeps
// a display copy that either follows the live count (one cycle behind) or
// stays frozen.
//
// count_en and display_en are plain levels from the control stage; there
// is no valid/ready handshake on this block, every edge samples both.
//
// Build option: define STOPWATCH_SATURATE_EN to stop at 59:59.99 instead
// of wrapping to 00:00.00; wrapped then means "saturated".
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              count_en,
  input  logic              display_en,
  output logic [TIME_W-1:0] disp_digits,
  output logic [TIME_W-1:0] live_digits,
  output logic              tick,
  output logic              wrapped
);

  localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  generate
    if ((TICK_HZ <= 0) || (DIV < 2) || ((DIV * TICK_HZ) != CLK_HZ)) begin : g_bad_div
      $error("stopwatch_time_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  logic [PW-1:0]      presc;
  logic               step;
  logic               chain_inc;
  logic               wrap_evt;
  logic [5:0]         carry;
  logic [DIGIT_W-1:0] d_cs_lo, d_cs_hi, d_sec_lo, d_sec_hi, d_min_lo, d_min_hi;

  // A 10 ms increment is due on this edge.
  assign step = count_en && (presc == LAST);

`ifdef STOPWATCH_SATURATE_EN
  logic at_max;
  assign at_max = (d_min_hi == 4'(MIN_HI_MAX)) && (d_min_lo == 4'(MIN_LO_MAX)) &&
                  (d_sec_hi == 4'(SEC_HI_MAX)) && (d_sec_lo == 4'(SEC_LO_MAX)) &&
                  (d_cs_hi  == 4'(CS_HI_MAX))  && (d_cs_lo  == 4'(CS_LO_MAX));
  // Hold the chain at 59:59.99; the top carry can then never fire.
  assign chain_inc = step && !at_max;
  assign wrap_evt  = (step && at_max) || carry[5];
`else
  assign chain_inc = step;
  assign wrap_evt  = carry[5];
`endif

  bcd_digit #(.MAX(CS_LO_MAX)) u_cs_lo (
    .clk(clk), .reset(reset), .inc(chain_inc), .value(d_cs_lo), .carry_out(carry[0])
  );
  bcd_digit #(.MAX(CS_HI_MAX)) u_cs_hi (
    .clk(clk), .reset(reset), .inc(carry[0]), .value(d_cs_hi), .carry_out(carry[1])
  );
  bcd_digit #(.MAX(SEC_LO_MAX)) u_sec_lo (
    .clk(clk), .reset(reset), .inc(carry[1]), .value(d_sec_lo), .carry_out(carry[2])
  );
  bcd_digit #(.MAX(SEC_HI_MAX)) u_sec_hi (
    .clk(clk), .reset(reset), .inc(carry[2]), .value(d_sec_hi), .carry_out(carry[3])
  );
  bcd_digit #(.MAX(MIN_LO_MAX)) u_min_lo (
    .clk(clk), .reset(reset), .inc(carry[3]), .value(d_min_lo), .carry_out(carry[4])
  );
  bcd_digit #(.MAX(MIN_HI_MAX)) u_min_hi (
    .clk(clk), .reset(reset), .inc(carry[4]), .value(d_min_hi), .carry_out(carry[5])
  );

  assign live_digits[CS_LO_OFF  +: DIGIT_W] = d_cs_lo;
  assign live_digits[CS_HI_OFF  +: DIGIT_W] = d_cs_hi;
  assign live_digits[SEC_LO_OFF +: DIGIT_W] = d_sec_lo;
  assign live_digits[SEC_HI_OFF +: DIGIT_W] = d_sec_hi;
  assign live_digits[MIN_LO_OFF +: DIGIT_W] = d_min_lo;
  assign live_digits[MIN_HI_OFF +: DIGIT_W] = d_min_hi;

  // Prescaler, registered tick pulse and sticky wrapped flag; a pause
  // keeps the partial interval so resuming does not restart it.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      tick    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      tick <= step;
      if (count_en) begin
        presc <= (presc == LAST) ? '0 : presc + 1'b1;
      end
      if (wrap_evt) begin
        wrapped <= 1'b1;
      end
    end
  end

  // Display copy samples the pre-increment live value while enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_digits <= '0;
    end else if (display_en) begin
      disp_digits <= live_digits;
    end
  end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter with CLK_HZ=1000, TICK_HZ=100
// (DIV=10). Inputs are driven and outputs sampled on the falling edge.
// Expected saturate/wrap behaviour follows STOPWATCH_SATURATE_EN.
module tb_stopwatch_time_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        count_en = 1'b0;
  logic        display_en = 1'b1;
  logic [23:0] disp_digits;
  logic [23:0] live_digits;
  logic        tick;
  logic        wrapped;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stopwatch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk),
    .reset(reset),
    .count_en(count_en),
    .display_en(display_en),
    .disp_digits(disp_digits),
    .live_digits(live_digits),
    .tick(tick),
    .wrapped(wrapped)
  );

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    count_en = 1'b0;
    display_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    cycles(2);
    vectors++; if (live_digits !== 24'h000000) begin miscompares++; $display("FAIL reset_live: got %h want %h", live_digits, 24'h000000); end
    vectors++; if (disp_digits !== 24'h000000) begin miscompares++; $display("FAIL reset_disp: got %h want %h", disp_digits, 24'h000000); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", tick); end
    vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
    reset = 1'b0;
  endtask

  task automatic test_first_tick();
    do_reset();
    count_en = 1'b1;
    cycles(9);
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL first_tick_early: got %b want 0", tick); end
    vectors++; if (live_digits !== 24'h000000) begin miscompares++; $display("FAIL first_tick_early_live: got %h want %h", live_digits, 24'h000000); end
    cycles(1);
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL first_tick_pulse: got %b want 1", tick); end
    vectors++; if (live_digits !== 24'h000001) begin miscompares++; $display("FAIL first_tick_live: got %h want %h", live_digits, 24'h000001); end
    vectors++; if (disp_digits !== 24'h000000) begin miscompares++; $display("FAIL first_tick_disp_lag: got %h want %h", disp_digits, 24'h000000); end
    count_en = 1'b0;
    cycles(1);
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL first_tick_one_cycle: got %b want 0", tick); end
    vectors++; if (disp_digits !== 24'h000001) begin miscompares++; $display("FAIL first_tick_disp: got %h want %h", disp_digits, 24'h000001); end
  endtask

  task automatic test_pause();
    int tick_seen;
    do_reset();
    count_en = 1'b1;
    cycles(4);
    count_en = 1'b0;
    tick_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      tick_seen += int'(tick);
    end
    vectors++; if (tick_seen != 0) begin miscompares++; $display("FAIL pause_no_tick: got %0d pulses want 0", tick_seen); end
    count_en = 1'b1;
    cycles(5);
    vectors++; if (tick !== 1'b0 || live_digits !== 24'h000000) begin miscompares++; $display("FAIL pause_resume_early: got tick=%b live=%h want tick=0 live=000000", tick, live_digits); end
    cycles(1);
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL pause_resume_tick: got %b want 1", tick); end
    vectors++; if (live_digits !== 24'h000001) begin miscompares++; $display("FAIL pause_resume_live: got %h want %h", live_digits, 24'h000001); end
  endtask

  task automatic test_carry();
    do_reset();
    count_en = 1'b1;
    cycles(9990);
    vectors++; if (live_digits !== 24'h000999) begin miscompares++; $display("FAIL carry_preload: got %h want %h", live_digits, 24'h000999); end
    cycles(9);
    vectors++; if (live_digits !== 24'h000999) begin miscompares++; $display("FAIL carry_hold: got %h want %h", live_digits, 24'h000999); end
    cycles(1);
    vectors++; if (live_digits !== 24'h001000) begin miscompares++; $display("FAIL carry_ripple: got %h want %h", live_digits, 24'h001000); end
    count_en = 1'b0;
  endtask

  task automatic test_wrap();
    int tick_count;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
`ifdef STOPWATCH_SATURATE_EN
    exp_first = 24'h595999;
    exp_last  = 24'h595999;
`else
    exp_first = 24'h000000;
    exp_last  = 24'h000004;
`endif
    do_reset();
    force dut.u_min_hi.value = 4'd5;
    force dut.u_min_lo.value = 4'd9;
    force dut.u_sec_hi.value = 4'd5;
    force dut.u_sec_lo.value = 4'd9;
    force dut.u_cs_hi.value  = 4'd9;
    force dut.u_cs_lo.value  = 4'd9;
    cycles(1);
    release dut.u_min_hi.value;
    release dut.u_min_lo.value;
    release dut.u_sec_hi.value;
    release dut.u_sec_lo.value;
    release dut.u_cs_hi.value;
    release dut.u_cs_lo.value;
    cycles(1);
    vectors++; if (live_digits !== 24'h595999) begin miscompares++; $display("FAIL wrap_preload: got %h want %h", live_digits, 24'h595999); end
    vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL wrap_not_yet: got %b want 0", wrapped); end
    count_en = 1'b1;
    cycles(10);
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL wrap_tick: got %b want 1", tick); end
    vectors++; if (live_digits !== exp_first) begin miscompares++; $display("FAIL wrap_live: got %h want %h", live_digits, exp_first); end
    vectors++; if (wrapped !== 1'b1) begin miscompares++; $display("FAIL wrap_flag: got %b want 1", wrapped); end
    tick_count = 1;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      tick_count += int'(tick);
    end
    vectors++; if (tick_count != 5) begin miscompares++; $display("FAIL wrap_tick_count: got %0d want 5", tick_count); end
    vectors++; if (live_digits !== exp_last) begin miscompares++; $display("FAIL wrap_live_after: got %h want %h", live_digits, exp_last); end
    vectors++; if (wrapped !== 1'b1) begin miscompares++; $display("FAIL wrap_sticky: got %b want 1", wrapped); end
    count_en = 1'b0;
  endtask

  task automatic test_freeze();
    logic [23:0] exp_v;
    do_reset();
    count_en = 1'b1;
    cycles(51);
    exp_q.push_back(24'h000005);
    display_en = 1'b0;
    cycles(300);
    exp_v = exp_q.pop_front();
    vectors++; if (disp_digits !== exp_v) begin miscompares++; $display("FAIL freeze_disp: got %h want %h", disp_digits, exp_v); end
    vectors++; if (live_digits !== 24'h000035) begin miscompares++; $display("FAIL freeze_live: got %h want %h", live_digits, 24'h000035); end
    exp_q.push_back(24'h000035);
    count_en = 1'b0;
    display_en = 1'b1;
    cycles(1);
    exp_v = exp_q.pop_front();
    vectors++; if (disp_digits !== exp_v) begin miscompares++; $display("FAIL unfreeze_disp: got %h want %h", disp_digits, exp_v); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    count_en = 1'b1;
    cycles(1239);
    vectors++; if (live_digits !== 24'h000123) begin miscompares++; $display("FAIL midreset_preload: got %h want %h", live_digits, 24'h000123); end
    reset = 1'b1;
    cycles(1);
    vectors++; if (live_digits !== 24'h000000) begin miscompares++; $display("FAIL midreset_live: got %h want %h", live_digits, 24'h000000); end
    vectors++; if (disp_digits !== 24'h000000) begin miscompares++; $display("FAIL midreset_disp: got %h want %h", disp_digits, 24'h000000); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL midreset_tick: got %b want 0", tick); end
    vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL midreset_wrapped: got %b want 0", wrapped); end
    reset = 1'b0;
    cycles(10);
    vectors++; if (live_digits !== 24'h000001) begin miscompares++; $display("FAIL midreset_restart: got %h want %h", live_digits, 24'h000001); end
    count_en = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_tick();
    test_pause();
    test_carry();
    test_wrap();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
